// File: rtl/ps2_key_controller.sv
// PS/2 keyboard front end: filtered frame receiver plus scan-code decoder driving active-low keys.
// Optional define PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module ps2_key_controller #(
   parameter int unsigned FILTER_LEN = 4,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       p1p,
   output logic       p1m,
   output logic       p2p,
   output logic       p2m,
   output logic       serve,
   output logic       start,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   logic [1:0]    clk_sync_q, data_sync_q;
   logic          clk_s, data_s;
   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;

   state_e        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          accept, drop, stop_ok;

   // Key vector order: {p1p, p1m, p2p, p2m, serve, start}
   logic [5:0]    keys_q, keys_d;
   logic          brk_q, brk_d, ext_q, ext_d;
   logic [7:0]    code_q, code_d;
   logic          cv_q, cv_d, fe_q, fe_d;

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];

   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (clk_s != filt_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_s;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign fall = filt_q & ~filt_d;

`ifdef PS2_PARITY_CHECK_EN
   assign stop_ok = data_s & (^{shift_q, par_q});
`else
   assign stop_ok = data_s;
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      accept    = 1'b0;
      drop      = 1'b0;
      to_cnt_d  = (state_q == StIdle) ? '0 : to_cnt_q + 1'b1;
      if (fall) begin
         to_cnt_d = '0;
         unique case (state_q)
            StIdle: begin
               if (!data_s) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end
            end
            StData: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = StParity;
            end
            StParity: begin
               par_d   = data_s;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               accept  = stop_ok;
               drop    = ~stop_ok;
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle && to_cnt_q == TW'(TIMEOUT - 1)) begin
         state_d  = StIdle;
         shift_d  = '0;
         to_cnt_d = '0;
         drop     = 1'b1;
      end
   end

   // Decoding happens on the accept edge so keys change in the code_valid cycle.
   always_comb begin
      keys_d = keys_q;
      brk_d  = brk_q;
      ext_d  = ext_q;
      code_d = code_q;
      cv_d   = accept;
      fe_d   = drop;
      if (accept) begin
         code_d = shift_q;
         if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else begin
            brk_d = 1'b0;
            ext_d = 1'b0;
            if (shift_q == 8'hAA && !ext_q) begin
               keys_d = '1;
            end else begin
               case ({ext_q, shift_q})
                  9'h01D:  keys_d[5] = brk_q;
                  9'h01B:  keys_d[4] = brk_q;
                  9'h175:  keys_d[3] = brk_q;
                  9'h172:  keys_d[2] = brk_q;
                  9'h029:  keys_d[1] = brk_q;
                  9'h05A:  keys_d[0] = brk_q;
                  default: keys_d    = keys_q;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         to_cnt_q    <= '0;
         keys_q      <= '1;
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         code_q      <= '0;
         cv_q        <= 1'b0;
         fe_q        <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         to_cnt_q    <= to_cnt_d;
         keys_q      <= keys_d;
         brk_q       <= brk_d;
         ext_q       <= ext_d;
         code_q      <= code_d;
         cv_q        <= cv_d;
         fe_q        <= fe_d;
      end
   end

   assign {p1p, p1m, p2p, p2m, serve, start} = keys_q;
   assign code       = code_q;
   assign code_valid = cv_q;
   assign frame_err  = fe_q;

endmodule

// File: doc/ps2_key_controller.md
Name: ps2_key_controller

Overview:
PS/2 keyboard front end for the paddle game; sits directly upstream of the game top level and replaces or parallels the board push-buttons.
- Receives PS/2 device-to-host frames, decodes make/break/extended scan codes, and holds one level per game control.
- Control outputs are active-low levels, matching the button convention the top level expects (pressed = 0).
- Outputs feed the existing debouncer, serve and start inputs unchanged.

Parameters:
FILTER_LEN, 4, clk cycles the synchronized ps2_clk must stay stable before its filtered value changes.
TIMEOUT, 50000, clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
clk  input  1  system clock; the only clock in the block
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from the connector, asynchronous
ps2_data  input  1  raw PS/2 data from the connector, asynchronous
p1p  output  1  player 1 up, active-low level (key W, 0x1D)
p1m  output  1  player 1 down, active-low level (key S, 0x1B)
p2p  output  1  player 2 up, active-low level (E0 75, up arrow)
p2m  output  1  player 2 down, active-low level (E0 72, down arrow)
serve  output  1  serve, active-low level (space, 0x29)
start  output  1  start, active-low level (enter, 0x5A)
code  output  8  last received data byte
code_valid  output  1  one-cycle pulse when a frame is accepted
frame_err  output  1  one-cycle pulse when a frame is dropped

Behaviour:
- Reset values:
  - All six key outputs = 1 (released).
  - code = 0x00; code_valid = 0; frame_err = 0.
  - Receiver FSM = IDLE; brk and ext flags = 0; filter and timeout counters = 0.
  - Filtered ps2_clk = 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The filtered ps2_clk takes the synchronized value only after it has been constant for FILTER_LEN consecutive cycles.
  - A falling edge is filtered 1 -> 0. Synchronized ps2_data is sampled in the edge cycle.
- Receiver FSM (advances on each falling edge only):
  - IDLE: sampled 0 -> DATA, bit count = 0. Sampled 1 -> stay in IDLE, no error.
  - DATA: shift the sample in LSB-first. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: return to IDLE.
    - Sampled 1: frame accepted. Next cycle, code = byte and code_valid = 1.
    - Sampled 0: frame dropped. Next cycle, frame_err = 1.
- Timeout:
  - The counter counts while the FSM is not in IDLE and clears on every falling edge.
  - Reaching TIMEOUT-1: FSM -> IDLE, partial byte discarded, frame_err pulses for one cycle.
  - brk and ext are kept on timeout.
- Decoder (acts only in the code_valid cycle; key outputs change in that same cycle):
  - 0xF0: set brk.
  - 0xE0: set ext.
  - 0xAA with ext = 0: all keys -> 1 (released); clear brk and ext.
  - Mapped {ext, byte}: target output = brk ? 1 : 0; clear brk and ext.
  - Unmapped byte: no output change; clear brk and ext.
  - A mapped code with the wrong ext (for example 0x75 without E0) counts as unmapped.
- Repeats and simultaneity:
  - Typematic repeats of a make code re-drive 0; this is idempotent.
  - Several keys may be held at once; each output is independent.
- rst asserted mid-frame or mid-prefix returns everything to its reset values on the next clk edge.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined:
  - In STOP, the frame is accepted only if the stop bit = 1 AND the XOR of the 8 data bits and the parity bit = 1 (odd parity).
  - Otherwise frame_err pulses, there is no code_valid pulse, and decoder state is unchanged.
- Undefined:
  - The parity bit is sampled but ignored; only the stop bit is checked.

Test Plan:
- Reset, then idle for 100 cycles -> all key outputs 1, code = 0x00, no pulses on code_valid or frame_err.
- Send frame 0x1D (parity 1, stop 1) -> single code_valid pulse with code = 0x1D and p1p = 0 in that cycle. Then send F0, 1D -> p1p returns to 1; p1m, p2p, p2m, serve and start stay 1 throughout.
- Send E0, 75 -> p2p = 0. Send 0x75 alone -> no change. Send E0, F0, 75 -> p2p = 1.
- Press W, S, space and enter (1D, 1B, 29, 5A) -> p1p = p1m = serve = start = 0. Send 0xAA -> all six outputs = 1.
- Send 0x29 with stop bit 0 -> frame_err pulse, no code_valid, serve stays 1. Send 0x29 with a corrupted parity bit -> with PS2_PARITY_CHECK_EN, frame_err pulse and serve stays 1; without it, serve = 0.
- Stop ps2_clk after 4 data bits for TIMEOUT cycles -> frame_err pulse, FSM in IDLE. A following full 0x5A frame -> start = 0.
